// File: rtl/audio_sd_output_if.sv
// Sample-stream interface for the audio back end: sample/mute/volume in,
// 1-bit audio pin and ramp status out.
interface audio_sd_output_if #(
    parameter int A_BITS   = 11,
    parameter int VOL_BITS = 2
);
    logic                       sample_valid;
    logic signed [A_BITS-1:0]   sample;
    logic                       mute;
    logic [VOL_BITS-1:0]        volume;
    logic                       audio_out;
    logic                       muted;
    logic                       ramping;

    modport master (
        output sample_valid, sample, mute, volume,
        input  audio_out, muted, ramping
    );

    modport slave (
        input  sample_valid, sample, mute, volume,
        output audio_out, muted, ramping
    );
endinterface

// File: rtl/audio_sd_output.sv
// Audio back end: sample hold, soft-mute gain ramp, volume shift and a
// first-order delta-sigma modulator driving the 1-bit audio pin.
module audio_sd_output #(
    parameter int A_BITS    = 11,
    parameter int GAIN_BITS = 5,
    parameter int VOL_BITS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    audio_sd_output_if.slave  bus
);
    localparam int PW = A_BITS + GAIN_BITS + 1;

    localparam logic [1:0] ST_MUTED     = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_PLAYING   = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    localparam logic [GAIN_BITS:0] GAIN_ZERO = '0;
    localparam logic [GAIN_BITS:0] GAIN_ONE  = {{GAIN_BITS{1'b0}}, 1'b1};
    localparam logic [GAIN_BITS:0] GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};

    logic signed [A_BITS-1:0] s_hold_reg;
    logic [GAIN_BITS:0]       gain_reg, gain_next;
    logic [1:0]               state_reg, state_next;
    logic signed [A_BITS-1:0] scaled_reg, scaled_next;
    logic [A_BITS-1:0]        acc_reg;
    logic                     audio_out_reg;

    logic signed [PW-1:0]     s_ext, g_ext, prod, att;
    logic [A_BITS-1:0]        u;
    logic [A_BITS:0]          sum;

    // Sample hold
    always_ff @(posedge clk) begin
        if (reset) begin
            s_hold_reg <= '0;
        end else if (bus.sample_valid) begin
            s_hold_reg <= bus.sample;
        end
    end

    // Gain ramp FSM; the bounds checks also cover a direction reversal at
    // either end of the range, so gain can never step outside 0..FULL.
    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        case (state_reg)
            ST_MUTED: begin
                gain_next = GAIN_ZERO;
                if (!bus.mute) begin
                    state_next = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (bus.mute) begin
                    state_next = ST_RAMP_DOWN;
                end else if (bus.sample_valid) begin
                    if (gain_reg >= GAIN_FULL - GAIN_ONE) begin
                        gain_next  = GAIN_FULL;
                        state_next = ST_PLAYING;
                    end else begin
                        gain_next = gain_reg + GAIN_ONE;
                    end
                end
            end
            ST_PLAYING: begin
                gain_next = GAIN_FULL;
                if (bus.mute) begin
                    state_next = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (!bus.mute) begin
                    state_next = ST_RAMP_UP;
                end else if (bus.sample_valid) begin
                    if (gain_reg <= GAIN_ONE) begin
                        gain_next  = GAIN_ZERO;
                        state_next = ST_MUTED;
                    end else begin
                        gain_next = gain_reg - GAIN_ONE;
                    end
                end
            end
            default: begin
                gain_next  = GAIN_ZERO;
                state_next = ST_MUTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_MUTED;
            gain_reg  <= GAIN_ZERO;
        end else begin
            state_reg <= state_next;
            gain_reg  <= gain_next;
        end
    end

    // Gain multiply and volume shift; both shifts floor toward -inf.
    always_comb begin
        s_ext       = PW'(s_hold_reg);
        g_ext       = $signed(PW'(gain_reg));
        prod        = s_ext * g_ext;
        att         = (prod >>> GAIN_BITS) >>> bus.volume;
        scaled_next = att[A_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scaled_reg <= '0;
        end else begin
            scaled_reg <= scaled_next;
        end
    end

    // Offset binary: flipping the sign bit maps zero to mid-scale.
    genvar gi;
    generate
        for (gi = 0; gi < A_BITS; gi++) begin : g_offset
            if (gi == A_BITS - 1) begin : g_msb
                assign u[gi] = ~scaled_reg[gi];
            end else begin : g_lsb
                assign u[gi] = scaled_reg[gi];
            end
        end
    endgenerate

    assign sum = {1'b0, acc_reg} + {1'b0, u};

    // First-order delta-sigma: carry out of the accumulator is the bitstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg       <= '0;
            audio_out_reg <= 1'b0;
        end else begin
            acc_reg       <= sum[A_BITS-1:0];
            audio_out_reg <= sum[A_BITS];
        end
    end

    assign bus.audio_out = audio_out_reg;
    assign bus.muted     = (state_reg == ST_MUTED);
    assign bus.ramping   = (state_reg == ST_RAMP_UP) || (state_reg == ST_RAMP_DOWN);
endmodule

// File: tb/tb_audio_sd_output.sv
// Self-checking bench for audio_sd_output: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_audio_sd_output;
    localparam int A_BITS    = 11;
    localparam int GAIN_BITS = 5;
    localparam int VOL_BITS  = 2;
    localparam int FULL      = 32;
    localparam int HALF      = 1024;
    localparam int MODV      = 2048;

    localparam int PH_MUTED = 0;
    localparam int PH_UP    = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_DOWN  = 3;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    audio_sd_output_if #(.A_BITS(A_BITS), .VOL_BITS(VOL_BITS)) bus ();

    audio_sd_output #(.A_BITS(A_BITS), .GAIN_BITS(GAIN_BITS), .VOL_BITS(VOL_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int   m_shold, m_gain, m_scaled, m_acc, m_phase;
    logic m_out;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Advance one clock: update the model from pre-edge inputs, then settle.
    task automatic step();
        int tot, n_scaled, n_shold, n_gain, n_phase;
        @(posedge clk);
        if (reset) begin
            m_shold = 0; m_gain = 0; m_scaled = 0; m_acc = 0; m_out = 1'b0;
            m_phase = PH_MUTED;
        end else begin
            tot      = m_acc + m_scaled + HALF;
            n_scaled = floor_div(floor_div(m_shold * m_gain, FULL), 1 << bus.volume);
            n_shold  = bus.sample_valid ? int'(bus.sample) : m_shold;
            n_gain   = m_gain;
            n_phase  = m_phase;
            case (m_phase)
                PH_MUTED: if (!bus.mute) n_phase = PH_UP;
                PH_UP: begin
                    if (bus.mute) n_phase = PH_DOWN;
                    else if (bus.sample_valid) begin
                        n_gain = (m_gain + 1 > FULL) ? FULL : m_gain + 1;
                        if (n_gain == FULL) n_phase = PH_PLAY;
                    end
                end
                PH_PLAY: if (bus.mute) n_phase = PH_DOWN;
                default: begin
                    if (!bus.mute) n_phase = PH_UP;
                    else if (bus.sample_valid) begin
                        n_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
                        if (n_gain == 0) n_phase = PH_MUTED;
                    end
                end
            endcase
            m_out    = (tot >= MODV);
            m_acc    = tot % MODV;
            m_scaled = n_scaled;
            m_shold  = n_shold;
            m_gain   = n_gain;
            m_phase  = n_phase;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mute = 1'b1; bus.sample = 11'sd500; bus.sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.audio_out !== 1'b0 || bus.muted !== 1'b1 || bus.ramping !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%b muted=%b ramping=%b expected 0 1 0",
                     bus.audio_out, bus.muted, bus.ramping);
        end
        checks++;
        if (dut.gain_reg !== 6'd0 || dut.scaled_reg !== 11'sd0) begin
            errors++;
            $display("FAIL reset_regs gain=%0d scaled=%0d expected 0 0", dut.gain_reg, dut.scaled_reg);
        end
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus.sample_valid = (i % 8 == 0);
            step();
            bus.sample_valid = 1'b0;
            checks++;
            if (bus.audio_out !== 1'(i & 1) || bus.muted !== 1'b1) begin
                errors++;
                $display("FAIL silence_pattern cycle=%0d out=%b muted=%b expected %0d 1",
                         i, bus.audio_out, bus.muted, i & 1);
            end
        end
    endtask

    task automatic test_ramp_up();
        int ones;
        bus.mute = 1'b0; bus.volume = 2'd0; bus.sample = 11'sd512;
        step();
        checks++;
        if (bus.ramping !== 1'b1 || bus.muted !== 1'b0) begin
            errors++;
            $display("FAIL enter_ramp ramping=%b muted=%b expected 1 0", bus.ramping, bus.muted);
        end
        for (int p = 1; p <= 32; p++) begin
            bus.sample_valid = 1'b1;
            step();
            bus.sample_valid = 1'b0;
            checks++;
            if (dut.gain_reg !== 6'(p) || bus.ramping !== (p < 32)) begin
                errors++;
                $display("FAIL ramp_step pulse=%0d gain=%0d ramping=%b expected %0d %b",
                         p, dut.gain_reg, bus.ramping, p, p < 32);
            end
            step(); step();
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (dut.scaled_reg !== 11'sd512) begin
            errors++;
            $display("FAIL full_gain_scaled got=%0d expected 512", dut.scaled_reg);
        end
        ones = 0;
        for (int i = 0; i < 1024; i++) begin step(); ones += int'(bus.audio_out); end
        checks++;
        if (ones != 768) begin
            errors++;
            $display("FAIL density_1536 ones=%0d expected 768", ones);
        end
    endtask

    task automatic test_volume();
        int ones;
        bus.volume = 2'd2; bus.sample = 11'sd512; bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (dut.scaled_reg !== 11'sd128) begin
            errors++;
            $display("FAIL volume_scaled got=%0d expected 128", dut.scaled_reg);
        end
        ones = 0;
        for (int i = 0; i < 2048; i++) begin step(); ones += int'(bus.audio_out); end
        checks++;
        if (ones != 1152) begin
            errors++;
            $display("FAIL density_1152 ones=%0d expected 1152", ones);
        end
    endtask

    task automatic test_extremes();
        int ones;
        bus.volume = 2'd0; bus.sample = -11'sd1024; bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
        step();
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if (bus.audio_out !== 1'b0) begin
                errors++;
                $display("FAIL negative_full cycle=%0d out=%b expected 0", i, bus.audio_out);
            end
        end
        bus.sample = 11'sd1023; bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        ones = 0;
        for (int i = 0; i < 2048; i++) begin step(); ones += int'(bus.audio_out); end
        checks++;
        if (ones != 2047) begin
            errors++;
            $display("FAIL density_2047 ones=%0d expected 2047", ones);
        end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1; bus.mute = 1'b1; step();
        reset = 1'b0; bus.mute = 1'b0; bus.sample = 11'sd512; step();
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (dut.gain_reg !== 6'd10) begin
            errors++;
            $display("FAIL ten_pulses gain=%0d expected 10", dut.gain_reg);
        end
        bus.mute = 1'b1;
        step();
        checks++;
        if (dut.gain_reg !== 6'd10 || bus.ramping !== 1'b1 || bus.muted !== 1'b0) begin
            errors++;
            $display("FAIL mute_reversal gain=%0d ramping=%b muted=%b expected 10 1 0",
                     dut.gain_reg, bus.ramping, bus.muted);
        end
        for (int i = 0; i < 10; i++) step();
        bus.sample_valid = 1'b0;
        checks++;
        if (dut.gain_reg !== 6'd0 || bus.muted !== 1'b1 || bus.ramping !== 1'b0) begin
            errors++;
            $display("FAIL ramp_down_done gain=%0d muted=%b ramping=%b expected 0 1 0",
                     dut.gain_reg, bus.muted, bus.ramping);
        end
        bus.mute = 1'b0; step();
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 16; i++) step();
        bus.sample_valid = 1'b0;
        step(); step();
        checks++;
        if (dut.gain_reg !== 6'd16 || dut.scaled_reg !== 11'sd256) begin
            errors++;
            $display("FAIL half_gain gain=%0d scaled=%0d expected 16 256", dut.gain_reg, dut.scaled_reg);
        end
    endtask

    task automatic test_reset_mid();
        bus.sample = 11'sd1023; bus.sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) step();
        bus.sample_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (bus.muted !== 1'b0 || bus.ramping !== 1'b0) begin
            errors++;
            $display("FAIL playing_before_reset muted=%b ramping=%b expected 0 0", bus.muted, bus.ramping);
        end
        reset = 1'b1; bus.mute = 1'b1; bus.sample_valid = 1'b1;
        step();
        reset = 1'b0; bus.sample_valid = 1'b0;
        checks++;
        if (bus.audio_out !== 1'b0 || bus.muted !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset out=%b muted=%b expected 0 1", bus.audio_out, bus.muted);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (bus.audio_out !== 1'(i & 1)) begin
                errors++;
                $display("FAIL post_reset_pattern cycle=%0d out=%b expected %0d", i, bus.audio_out, i & 1);
            end
        end
    endtask

    task automatic test_random();
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.mute = ~bus.mute;
            if ($urandom_range(0, 127) == 0) bus.volume = 2'($urandom_range(0, 3));
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.sample       = 11'($urandom_range(0, 2047));
            reset            = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if (bus.audio_out !== m_out || bus.muted !== (m_phase == PH_MUTED) ||
                bus.ramping !== (m_phase == PH_UP || m_phase == PH_DOWN)) begin
                errors++;
                $display("FAIL random_outputs cycle=%0d out=%b muted=%b ramping=%b expected %b %b %b",
                         i, bus.audio_out, bus.muted, bus.ramping, m_out,
                         m_phase == PH_MUTED, m_phase == PH_UP || m_phase == PH_DOWN);
            end
            checks++;
            if (int'(dut.scaled_reg) != m_scaled || int'(dut.gain_reg) != m_gain) begin
                errors++;
                $display("FAIL random_scaling cycle=%0d scaled=%0d gain=%0d expected %0d %0d",
                         i, dut.scaled_reg, dut.gain_reg, m_scaled, m_gain);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.sample_valid = 1'b0; bus.sample = '0; bus.mute = 1'b1; bus.volume = '0;
        m_shold = 0; m_gain = 0; m_scaled = 0; m_acc = 0; m_out = 1'b0; m_phase = PH_MUTED;
        #1;
        test_reset();
        test_ramp_up();
        test_volume();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
